// File: rtl/fir_pkg.sv
// Shared definitions for the FIR transmit-side feeder: state encoding,
// word-kind constants and the default geometry shared with the FIR itself.
package fir_pkg;

  localparam int TAP_SIZE_DEF    = 3;
  localparam int NBR_OF_TAPS_DEF = 3;
  localparam int X_N_SIZE_DEF    = 8;
  localparam int FIFO_DEPTH_DEF  = 4;

  localparam logic KIND_SAMPLE = 1'b0;
  localparam logic KIND_COEF   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_GAP    = 2'd3
  } feed_state_t;

endpackage

// File: rtl/fir_feed_fifo.sv
// Small synchronous sample FIFO; a push while full is only taken when a pop
// frees the slot in the same cycle.
module fir_feed_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fir_stream_feeder.sv
// Transmit-side driver for the adaptive FIR: collects coefficient sets and
// buffers samples from the host, then sequences load and stream bursts.
//
// state  | meaning
// IDLE   | nothing on the bus; pick LOAD (full set) over STREAM (samples)
// LOAD   | shift coefficients out, last-received first, one per cycle
// STREAM | pop one buffered sample per cycle onto x_n
// GAP    | one quiet cycle so the FIR's own FSM falls back to IDLE
module fir_stream_feeder
  import fir_pkg::*;
#(
  parameter int TAP_SIZE    = TAP_SIZE_DEF,
  parameter int NBR_OF_TAPS = NBR_OF_TAPS_DEF,
  parameter int X_N_SIZE    = X_N_SIZE_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [X_N_SIZE-1:0]         in_data,
  input  logic                        in_kind,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [X_N_SIZE-1:0]         x_n,
  output logic                        s_axis_fir_tvalid,
  output logic                        s_set_coeffs,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        coef_busy
);

  localparam int CW = $clog2(NBR_OF_TAPS + 1);
  localparam int IW = (NBR_OF_TAPS > 1) ? $clog2(NBR_OF_TAPS) : 1;

  feed_state_t         state, state_d;
  logic [CW-1:0]       coef_cnt;
  logic [TAP_SIZE-1:0] coef_bank [NBR_OF_TAPS];
  logic [IW-1:0]       load_idx, load_idx_d;
  logic                set_complete;
  logic                accept_coef;
  logic                accept_sample;
  logic                coef_clear;

  logic [X_N_SIZE-1:0] x_n_d;
  logic                tvalid_d;
  logic                set_coeffs_d;

  logic                fifo_pop;
  logic [X_N_SIZE-1:0] fifo_head;
  logic                fifo_full;
  logic                fifo_empty;

  assign set_complete  = (coef_cnt == CW'(NBR_OF_TAPS));
  assign accept_coef   = in_valid && in_ready && (in_kind == KIND_COEF);
  assign accept_sample = in_valid && in_ready && (in_kind == KIND_SAMPLE);
  assign coef_busy     = (coef_cnt != '0) || (state == ST_LOAD);

  always_comb begin
    in_ready = 1'b0;
    if (in_kind == KIND_COEF)
      in_ready = (coef_cnt < CW'(NBR_OF_TAPS)) && (state != ST_LOAD);
    else
      in_ready = !fifo_full;
  end

  fir_feed_fifo #(
    .WIDTH(X_N_SIZE),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept_sample),
    .push_data(in_data),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef_cnt <= '0;
      for (int k = 0; k < NBR_OF_TAPS; k++) coef_bank[k] <= '0;
    end else if (coef_clear) begin
      coef_cnt <= '0;
    end else if (accept_coef) begin
      coef_bank[IW'(coef_cnt)] <= in_data[TAP_SIZE-1:0];
      coef_cnt                 <= coef_cnt + 1'b1;
    end
  end

  // load_idx counts down so coef[0] is the last word shifted into the FIR.
  always_comb begin
    state_d      = state;
    load_idx_d   = load_idx;
    x_n_d        = '0;
    tvalid_d     = 1'b0;
    set_coeffs_d = 1'b0;
    fifo_pop     = 1'b0;
    coef_clear   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (set_complete) begin
          state_d    = ST_LOAD;
          load_idx_d = IW'(NBR_OF_TAPS - 1);
        end else if (!fifo_empty) begin
          state_d = ST_STREAM;
        end
      end
      ST_LOAD: begin
        set_coeffs_d = 1'b1;
        x_n_d        = X_N_SIZE'($signed(coef_bank[load_idx]));
        if (load_idx == '0) begin
          coef_clear = 1'b1;
          state_d    = ST_GAP;
        end else begin
          load_idx_d = load_idx - 1'b1;
        end
      end
      ST_STREAM: begin
        if (!fifo_empty) begin
          x_n_d    = fifo_head;
          tvalid_d = 1'b1;
          fifo_pop = 1'b1;
        end
        if (fifo_empty || set_complete) state_d = ST_GAP;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      load_idx          <= '0;
      x_n               <= '0;
      s_axis_fir_tvalid <= 1'b0;
      s_set_coeffs      <= 1'b0;
    end else begin
      state             <= state_d;
      load_idx          <= load_idx_d;
      x_n               <= x_n_d;
      s_axis_fir_tvalid <= tvalid_d;
      s_set_coeffs      <= set_coeffs_d;
    end
  end

endmodule
